// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous RAM between the instruction-fetch
// requester and the data (load/store) requester. At most one request is
// granted per cycle. The grant drives the RAM port combinationally, and the
// one-cycle-latency read data is routed back to the owner on the next cycle.
// Data has fixed priority. A saturating starvation counter forces fetch ahead
// of data after STARVE_LIMIT consecutive lost arbitrations, so fetch always
// makes progress.
//
// Parameters:
//   XLEN          address width
//   STARVE_LIMIT  consecutive fetch losses before fetch is forced (1..15)
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   if_req_valid/addr/ready    fetch request channel (valid/ready)
//   if_rsp_valid/rdata         fetch response, one cycle after the grant
//   d_req_valid/addr/we/wdata/wstrb/ready   data request channel
//   d_rsp_valid/rdata          data response (read data, or 0 for write ack)
//   mem_en/we/addr/wdata/wstrb RAM port, driven by the granted request
//   mem_rdata                  RAM read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  // fetch requester
  input  logic            if_req_valid,
  input  logic [XLEN-1:0] if_req_addr,
  output logic            if_req_ready,
  output logic            if_rsp_valid,
  output logic [31:0]     if_rsp_rdata,
  // data requester
  input  logic            d_req_valid,
  input  logic [XLEN-1:0] d_req_addr,
  input  logic            d_req_we,
  input  logic [31:0]     d_req_wdata,
  input  logic [3:0]      d_req_wstrb,
  output logic            d_req_ready,
  output logic            d_rsp_valid,
  output logic [31:0]     d_rsp_rdata,
  // RAM port
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [31:0]     mem_rdata
);

  // Owner of the RAM access issued in the previous cycle.
  typedef enum logic [1:0] {
    IDLE,
    RSP_IF,
    RSP_DR,
    RSP_DW
  } rsp_st_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  rsp_st_e    rsp_st_q, rsp_st_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  logic force_if;
  logic grant_if;
  logic grant_d;

  // ---------------------------------------------------------------------------
  // Grant decision. Nothing is granted while reset is held, so every output
  // derived from the grant is quiet during reset.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    force_if = if_req_valid && (starve_cnt_q == LIMIT);
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (rst_n) begin
      if (force_if) begin
        grant_if = 1'b1;
      end else if (d_req_valid) begin
        grant_d = 1'b1;
      end else if (if_req_valid) begin
        grant_if = 1'b1;
      end
    end
  end

  assign if_req_ready = grant_if;
  assign d_req_ready  = grant_d;

  // ---------------------------------------------------------------------------
  // RAM port, driven straight from the granted request.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (grant_if) begin
      mem_en   = 1'b1;
      mem_addr = if_req_addr;
    end else if (grant_d) begin
      mem_en    = 1'b1;
      mem_we    = d_req_we;
      mem_addr  = d_req_addr;
      mem_wdata = d_req_wdata;
      // Strobes mean nothing on a read; keep them zero so the RAM sees a
      // clean read command.
      mem_wstrb = d_req_we ? d_req_wstrb : 4'b0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state: response owner and starvation counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_st_d = IDLE;
    if (grant_if) begin
      rsp_st_d = RSP_IF;
    end else if (grant_d) begin
      rsp_st_d = d_req_we ? RSP_DW : RSP_DR;
    end

    // The counter only runs while fetch is waiting and losing; any fetch win
    // or an idle fetch side restarts the count.
    starve_cnt_d = '0;
    if (if_req_valid && !grant_if) begin
      starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value and simulation order cannot matter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_st_q     <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      rsp_st_q     <= rsp_st_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Responses, combinational from the owner of last cycle's access. Gated by
  // rst_n so an access in flight at reset never surfaces.
  // ---------------------------------------------------------------------------
  always_comb begin
    if_rsp_valid = 1'b0;
    if_rsp_rdata = '0;
    d_rsp_valid  = 1'b0;
    d_rsp_rdata  = '0;
    if (rst_n) begin
      unique case (rsp_st_q)
        RSP_IF: begin
          if_rsp_valid = 1'b1;
          if_rsp_rdata = mem_rdata;
        end
        RSP_DR: begin
          d_rsp_valid = 1'b1;
          d_rsp_rdata = mem_rdata;
        end
        RSP_DW: begin
          d_rsp_valid = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for mem_port_arbiter.
//
// A behavioural RAM hangs off the RAM port. A reference model tracks the
// expected grant, RAM command and response every cycle: it counts consecutive
// fetch losses as a plain integer, keeps its own copy of memory contents, and
// remembers which response is owed next cycle. On top of that, a table of
// directed vectors and a few hand-written sequences pin down the documented
// corner cases with constant expectations.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int XLEN  = 32;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_rdata;
  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_wstrb;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .XLEN        (XLEN),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req_valid(if_req_valid),
    .if_req_addr (if_req_addr),
    .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid),
    .if_rsp_rdata(if_rsp_rdata),
    .d_req_valid (d_req_valid),
    .d_req_addr  (d_req_addr),
    .d_req_we    (d_req_we),
    .d_req_wdata (d_req_wdata),
    .d_req_wstrb (d_req_wstrb),
    .d_req_ready (d_req_ready),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_rdata (d_rsp_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata)
  );

  // Behavioural single-port RAM: 256 words indexed by addr[9:2].
  logic [31:0] ram [0:255];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wstrb[b]) ram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end else begin
        ram_q <= ram[mem_addr[9:2]];
      end
    end
  end
  assign mem_rdata = ram_q;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef enum int {OWE_NONE, OWE_IF, OWE_DREAD, OWE_DWRITE} owe_e;

  logic [31:0] ref_mem [0:255];
  int          losses;     // consecutive lost fetch arbitrations
  owe_e        owed;       // response due this cycle
  logic [31:0] owed_data;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ifv, input logic [31:0] ifa,
                       input logic dv, input logic [31:0] da, input logic we,
                       input logic [31:0] wd, input logic [3:0] ws);
    @(posedge clk);
    #1;
    rst_n        = r;
    if_req_valid = ifv;
    if_req_addr  = ifa;
    d_req_valid  = dv;
    d_req_addr   = da;
    d_req_we     = we;
    d_req_wdata  = wd;
    d_req_wstrb  = ws;
  endtask

  // Compares the DUT against the model in the middle of the current cycle
  // (falling edge), then advances the model past the next rising edge.
  task automatic run_cycle(output logic g_if, output logic g_d);
    logic        fetch_forced;
    logic [37:0] exp_cmd;
    logic [31:0] exp_wd;
    logic        exp_ifv, exp_dv;
    logic [31:0] exp_ifd, exp_dd;
    @(negedge clk);
    g_if = 1'b0;
    g_d  = 1'b0;
    if (rst_n) begin
      fetch_forced = if_req_valid && (losses >= LIMIT);
      g_d  = d_req_valid && !fetch_forced;
      g_if = if_req_valid && !g_d;
    end
    check("ready", {94'd0, if_req_ready, d_req_ready}, {94'd0, g_if, g_d});

    exp_cmd = '0;
    exp_wd  = '0;
    if (g_if) exp_cmd = {1'b1, 1'b0, if_req_addr, 4'b0000};
    if (g_d) begin
      exp_cmd = {1'b1, d_req_we, d_req_addr, d_req_we ? d_req_wstrb : 4'b0000};
      exp_wd  = d_req_wdata;
    end
    check("mem_cmd", {58'd0, mem_en, mem_we, mem_addr, mem_wstrb}, {58'd0, exp_cmd});
    // Write data is irrelevant on a fetch grant.
    if (!g_if) check("mem_wdata", {64'd0, mem_wdata}, {64'd0, exp_wd});

    exp_ifv = 1'b0; exp_dv = 1'b0; exp_ifd = '0; exp_dd = '0;
    if (rst_n) begin
      case (owed)
        OWE_IF:     begin exp_ifv = 1'b1; exp_ifd = owed_data; end
        OWE_DREAD:  begin exp_dv  = 1'b1; exp_dd  = owed_data; end
        OWE_DWRITE: begin exp_dv  = 1'b1; end
        default: ;
      endcase
    end
    check("rsp", {30'd0, if_rsp_valid, d_rsp_valid, if_rsp_rdata, d_rsp_rdata},
                 {30'd0, exp_ifv, exp_dv, exp_ifd, exp_dd});

    // Advance the model.
    if (!rst_n) begin
      losses = 0;
      owed   = OWE_NONE;
    end else begin
      losses = (if_req_valid && !g_if) ? losses + 1 : 0;
      owed   = OWE_NONE;
      if (g_if) begin
        owed      = OWE_IF;
        owed_data = ref_mem[if_req_addr[9:2]];
      end else if (g_d && d_req_we) begin
        owed = OWE_DWRITE;
        for (int b = 0; b < 4; b++) begin
          if (d_req_wstrb[b]) ref_mem[d_req_addr[9:2]][b*8 +: 8] = d_req_wdata[b*8 +: 8];
        end
      end else if (g_d) begin
        owed      = OWE_DREAD;
        owed_data = ref_mem[d_req_addr[9:2]];
      end
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 'h40) return 32'hDEAD_BEEF;          // byte address 0x100
    if (i < 8)     return 32'hC0DE_0000 + 32'(i); // byte addresses 0x0..0x1C
    return 32'h0;
  endfunction

  // Directed vectors
  typedef struct {
    logic        r;
    logic        ifv;
    logic [31:0] ifa;
    logic        dv;
    logic [31:0] da;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        e_if_rdy;
    logic        e_d_rdy;
    logic        e_if_rv;
    logic [31:0] e_if_rd;
    logic        e_d_rv;
    logic [31:0] e_d_rd;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic gi, gd;
    logic        p_ifv, p_dv, p_we;
    logic [31:0] p_ifa, p_da, p_wd;
    logic [3:0]  p_ws;
    logic        r;

    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    losses = 0;
    owed   = OWE_NONE;
    owed_data = '0;
    rst_n = 1'b0;
    if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0;
    d_req_wdata = '0; d_req_wstrb = '0;

    // Reset, with requests present: everything must stay quiet.
    drive(0, 0, 0, 0, 0, 0, 0, 0);           run_cycle(gi, gd);
    drive(0, 1, 32'h40, 1, 32'h80, 1, 32'hFFFF_FFFF, 4'hF); run_cycle(gi, gd);

    // Fill the RAM through the data port.
    for (int i = 0; i < 256; i++) begin
      drive(1, 0, 0, 1, 32'(i * 4), 1, init_word(i), 4'hF);
      run_cycle(gi, gd);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0); run_cycle(gi, gd);

    // Directed table. Expected values are constants from the intended behaviour.
    //            r ifv ifa      dv da        we wd            ws     ifr dr ifv ifd           dv dd
    vecs[0]  = '{1, 1, 32'h100, 0, 32'h0,   0, 32'h0,        4'h0,  1,  0, 0, 32'h0,        0, 32'h0};
    vecs[1]  = '{1, 0, 32'h0,   0, 32'h0,   0, 32'h0,        4'h0,  0,  0, 1, 32'hDEADBEEF, 0, 32'h0};
    vecs[2]  = '{1, 0, 32'h0,   1, 32'h200, 1, 32'h11223344, 4'h3,  0,  1, 0, 32'h0,        0, 32'h0};
    vecs[3]  = '{1, 0, 32'h0,   1, 32'h200, 0, 32'h0,        4'h0,  0,  1, 0, 32'h0,        1, 32'h0};
    vecs[4]  = '{1, 0, 32'h0,   0, 32'h0,   0, 32'h0,        4'h0,  0,  0, 0, 32'h0,        1, 32'h00003344};
    vecs[5]  = '{1, 0, 32'h0,   1, 32'h100, 0, 32'h0,        4'h0,  0,  1, 0, 32'h0,        0, 32'h0};
    vecs[6]  = '{0, 0, 32'h0,   0, 32'h0,   0, 32'h0,        4'h0,  0,  0, 0, 32'h0,        0, 32'h0};
    vecs[7]  = '{1, 1, 32'h100, 0, 32'h0,   0, 32'h0,        4'h0,  1,  0, 0, 32'h0,        0, 32'h0};
    vecs[8]  = '{1, 0, 32'h0,   0, 32'h0,   0, 32'h0,        4'h0,  0,  0, 1, 32'hDEADBEEF, 0, 32'h0};
    vecs[9]  = '{0, 1, 32'h100, 1, 32'h200, 0, 32'h0,        4'h0,  0,  0, 0, 32'h0,        0, 32'h0};
    vecs[10] = '{1, 1, 32'h100, 1, 32'h200, 0, 32'h0,        4'h0,  0,  1, 0, 32'h0,        0, 32'h0};
    vecs[11] = '{1, 0, 32'h0,   0, 32'h0,   0, 32'h0,        4'h0,  0,  0, 0, 32'h0,        1, 32'h00003344};
    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].r, vecs[v].ifv, vecs[v].ifa, vecs[v].dv, vecs[v].da,
            vecs[v].we, vecs[v].wd, vecs[v].ws);
      run_cycle(gi, gd);
      check($sformatf("vec%0d_ready", v), {94'd0, if_req_ready, d_req_ready},
            {94'd0, vecs[v].e_if_rdy, vecs[v].e_d_rdy});
      check($sformatf("vec%0d_rsp", v), {30'd0, if_rsp_valid, d_rsp_valid, if_rsp_rdata, d_rsp_rdata},
            {30'd0, vecs[v].e_if_rv, vecs[v].e_d_rv, vecs[v].e_if_rd, vecs[v].e_d_rd});
      if (!vecs[v].r) check($sformatf("vec%0d_mem_en", v), {95'd0, mem_en}, 96'd0);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0); run_cycle(gi, gd);

    // Collision: fetch wins every fifth cycle, its response a cycle later.
    for (int c = 0; c < 20; c++) begin
      drive(1, 1, 32'h100, 1, 32'h200, 0, 0, 0);
      run_cycle(gi, gd);
      check($sformatf("coll%0d_if_rdy", c), {95'd0, if_req_ready}, {95'd0, (c % 5) == 4});
      check($sformatf("coll%0d_if_rsp", c), {95'd0, if_rsp_valid}, {95'd0, (c > 0) && ((c % 5) == 0)});
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0); run_cycle(gi, gd);

    // Starvation clear: 3 losses, fetch idle once, then 4 fresh losses first.
    for (int c = 0; c < 10; c++) begin
      drive(1, c != 3, 32'h100, 1, 32'h200, 0, 0, 0);
      run_cycle(gi, gd);
      check($sformatf("starve%0d_if_rdy", c), {95'd0, if_req_ready}, {95'd0, c == 8});
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0); run_cycle(gi, gd);

    // Back-to-back fetches with no bubbles.
    for (int c = 0; c < 9; c++) begin
      drive(1, c < 8, 32'(c * 4), 0, 0, 0, 0, 0);
      run_cycle(gi, gd);
      if (c > 0) begin
        check($sformatf("b2b%0d", c), {63'd0, if_rsp_valid, if_rsp_rdata},
              {63'd0, 1'b1, 32'hC0DE_0000 + 32'(c - 1)});
      end
    end

    // Randomised traffic; requesters hold their request until accepted.
    p_ifv = 1'b0; p_dv = 1'b0; p_we = 1'b0;
    p_ifa = '0; p_da = '0; p_wd = '0; p_ws = '0;
    for (int c = 0; c < 600; c++) begin
      if (!p_ifv) begin
        p_ifv = ($urandom_range(0, 99) < 60);
        p_ifa = $urandom;
      end
      if (!p_dv) begin
        p_dv = ($urandom_range(0, 99) < 65);
        p_da = $urandom;
        p_we = $urandom_range(0, 1) == 1;
        p_wd = $urandom;
        p_ws = 4'($urandom_range(0, 15));
      end
      r = ($urandom_range(0, 59) != 0);
      drive(r, p_ifv, p_ifa, p_dv, p_da, p_we, p_wd, p_ws);
      run_cycle(gi, gd);
      if (gi || !r) p_ifv = 1'b0;
      if (gd || !r) p_dv  = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous RAM between the pipelined core's instruction-fetch requester and data (load/store) requester. Each cycle it grants at most one request, drives the RAM port, and routes the one-cycle-latency read data back to the owner. Data has fixed priority, and a saturating starvation counter guarantees fetch progress. It sits between `staged_core`'s imem/dmem interfaces (adapted to valid/ready) and the unified RAM macro.

## Interface
- `XLEN`, 32, address width
- `STARVE_LIMIT`, 4, consecutive lost fetch arbitrations before fetch is forced ahead of data; legal range 1..15

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `if_req_valid`  in  1  fetch request
- `if_req_addr`  in  XLEN  fetch word address
- `if_req_ready`  out  1  fetch request accepted this cycle
- `if_rsp_valid`  out  1  fetch read data valid
- `if_rsp_rdata`  out  32  fetch read data
- `d_req_valid`  in  1  data request
- `d_req_addr`  in  XLEN  data address
- `d_req_we`  in  1  1 = write, 0 = read
- `d_req_wdata`  in  32  write data
- `d_req_wstrb`  in  4  byte strobes for writes
- `d_req_ready`  out  1  data request accepted this cycle
- `d_rsp_valid`  out  1  data response (read data or write ack)
- `d_rsp_rdata`  out  32  data read data; 0 for write acks
- `mem_en`  out  1  RAM access this cycle
- `mem_we`  out  1  RAM write
- `mem_addr`  out  XLEN  RAM address
- `mem_wdata`  out  32  RAM write data
- `mem_wstrb`  out  4  RAM byte strobes
- `mem_rdata`  in  32  RAM read data, valid the cycle after a read `mem_en`

## Operation
- Acceptance is `valid & ready`. Requesters hold valid, address, and payload stable until accepted.
- Grant decision is combinational in the same cycle:
  - `force_if = if_req_valid & (starve_cnt == STARVE_LIMIT)`.
  - If `force_if`: grant fetch.
  - Else if `d_req_valid`: grant data.
  - Else if `if_req_valid`: grant fetch.
  - Else: no grant.
- The granted `*_req_ready` is 1 and the other is 0.
- RAM port is combinational from the granted request:
  - `mem_en = 1`; `mem_addr` = granted address.
  - Fetch: `mem_we = 0`, `mem_wstrb = 0`.
  - Data: `mem_we = d_req_we`; `mem_wdata`/`mem_wstrb` from the data request, with `mem_wstrb` forced to 0 on data reads.
  - No grant: all `mem_*` outputs are 0.
- `starve_cnt` is a 4-bit register:
  - Increments, saturating at `STARVE_LIMIT`, when `if_req_valid` is 1 and fetch is not granted.
  - Clears to 0 when fetch is granted or `if_req_valid` is 0.
- Response-tracking FSM, state register `rsp_st`, which is the owner of the access issued last cycle:
  - States: `IDLE`, `RSP_IF`, `RSP_DR` (data read), `RSP_DW` (data write).
  - Next state: `RSP_IF` on fetch grant; `RSP_DR` or `RSP_DW` on data grant per `d_req_we`; `IDLE` with no grant.
  - Every state can transition to every state; back-to-back accesses are fully pipelined, one per cycle.
- Response outputs are combinational from `rsp_st`:
  - `RSP_IF`: `if_rsp_valid = 1`, `if_rsp_rdata = mem_rdata`.
  - `RSP_DR`: `d_rsp_valid = 1`, `d_rsp_rdata = mem_rdata`.
  - `RSP_DW`: `d_rsp_valid = 1`, `d_rsp_rdata = 0`.
  - All rsp data outputs are 0 when their valid is 0.
- No address alignment checks; the LSU upstream owns misalignment.

## Timing
- Request to response latency is exactly 1 cycle. A grant in cycle N gives the response in cycle N+1.
- Throughput is 1 access per cycle.
- Worst-case fetch wait with data continuously valid: `STARVE_LIMIT` lost cycles, then granted in the next cycle.
- Simultaneous valid requests:
  - Data wins unless `force_if`.
  - When `force_if` wins, the data request stalls that cycle and is granted the next cycle, with `starve_cnt` now 0.
- Reset (`rst_n` = 0 at a rising edge):
  - `rsp_st` becomes `IDLE` and `starve_cnt` becomes 0.
  - While `rst_n` = 0: both `*_req_ready` = 0, `mem_en` = 0, and all other outputs are 0.
- Reset mid-operation: an access in flight is dropped and no rsp_valid appears after reset. A RAM write already issued before the reset edge stands.
- The first cycle after reset deasserts can grant.

## Test plan
- **Single fetch:** `if_req_valid` = 1, addr `0x100`, RAM word `0xDEADBEEF` → cycle 0: `if_req_ready` = 1, `mem_en` = 1, `mem_addr` = `0x100`; cycle 1: `if_rsp_valid` = 1, `if_rsp_rdata` = `0xDEADBEEF`, `d_rsp_valid` = 0.
- **Data write then read:** write `0x200`, wdata `0x11223344`, wstrb `0b0011`; next cycle read `0x200` from a pre-zeroed word → write ack `d_rsp_valid` = 1 with rdata 0, then read returns `0x00003344`.
- **Collision:** both valid every cycle, `STARVE_LIMIT` = 4 → data granted in cycles 0–3, fetch in cycle 4, data again in cycles 5–8; this pattern repeats, and `if_rsp_valid` pulses in cycles 5, 10, 15.
- **Back-to-back pipelining:** 8 consecutive fetches to addrs `0x0`..`0x1C` with no data traffic → 8 consecutive `if_rsp_valid` cycles with matching data and no bubbles.
- **Starvation counter clear:** fetch loses 3 cycles, then drops valid for 1 cycle, then both valid continuously → the counter restarts, so fetch wins only after 4 further losses.
- **Reset mid-flight:** grant a read, assert `rst_n` = 0 on the next edge → no rsp_valid; all outputs are 0 during reset; `starve_cnt` = 0 afterwards; a fetch issued after release completes normally in 1 cycle.
